// File: rtl/ab_in_pkg.sv
// Shared types and defaults for the A/B switch input conditioning stage.
package ab_in_pkg;

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } ab_state_t;

    localparam int AB_DEBOUNCE_DEFAULT = 4;
    localparam int AB_CNT_W_DEFAULT    = 16;

endpackage

// File: rtl/ab_debounce_chan.sv
// One debounce channel: optional 2-flop synchronizer (AB_SW_SYNC_EN), stable/pending FSM and counter.
// commit is combinational and marks the edge on which level takes the new value.
module ab_debounce_chan
    import ab_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = AB_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = AB_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic commit
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    logic             mismatch;
    ab_state_t        state;
    logic [CNT_W-1:0] cnt;

`ifdef AB_SW_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[0], raw};
    end

    assign s = sync_q[1];
`else
    assign s = raw;
`endif

    assign mismatch = (s != level);

    // A single-cycle window commits straight from ST_STABLE without visiting ST_PENDING.
    always_comb begin
        commit = 1'b0;
        if (mismatch) begin
            if (state == ST_PENDING)
                commit = (cnt == LAST_CNT);
            else
                commit = (DEBOUNCE_CYCLES == 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STABLE;
            cnt   <= '0;
            level <= 1'b0;
        end else if (commit) begin
            level <= s;
            state <= ST_STABLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_STABLE: begin
                    if (mismatch) begin
                        state <= ST_PENDING;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_PENDING: begin
                    if (!mismatch) begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ab_switch_debounce.sv
// Debounces switches A and B and strobes ab_valid/changed_mask when the committed pair changes.
// Build option: define AB_SW_SYNC_EN to add a 2-flop synchronizer per switch.
module ab_switch_debounce
    import ab_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = AB_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = AB_CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_a,
    input  logic       sw_b,
    output logic       a_out,
    output logic       b_out,
    output logic       ab_valid,
    output logic [1:0] changed_mask
);

    logic commit_a;
    logic commit_b;

    ab_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sw_a),
        .level  (a_out),
        .commit (commit_a)
    );

    ab_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (sw_b),
        .level  (b_out),
        .commit (commit_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ab_valid     <= 1'b0;
            changed_mask <= '0;
        end else begin
            ab_valid     <= commit_a | commit_b;
            changed_mask <= {commit_a, commit_b};
        end
    end

endmodule
